// File: rtl/port_controller_pkg.sv
// port_controller_pkg: CPU port map, widths and shared types.
// The CPU and the board top import this so both agree on the map.
package port_controller_pkg;

    localparam int WORD_SIZE_DEF   = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int NUM_SW          = 8;
    localparam int NUM_BTN         = 4;
    localparam int SHOW_W          = 16;

    localparam int unsigned ADDR_DISP0 = 0;
    localparam int unsigned ADDR_DISP1 = 1;
    localparam int unsigned ADDR_SW    = 2;
    localparam int unsigned ADDR_BTNEV = 3;
    localparam int unsigned ADDR_TIMER = 4;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    typedef enum logic [2:0] {
        PORT_DISP0,
        PORT_DISP1,
        PORT_SW,
        PORT_BTNEV,
        PORT_TIMER,
        PORT_NONE
    } port_e;

    function automatic logic port_writable(input port_e p);
        return (p == PORT_DISP0) || (p == PORT_DISP1) || (p == PORT_TIMER);
    endfunction

endpackage

// File: rtl/port_controller_input_sync.sv
// input_sync: multi-flop synchronizers for switches and buttons,
// plus rising-edge detection on the synchronized buttons.
module input_sync
    import port_controller_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SW-1:0]  sw_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_SW-1:0]  sw_o,
    output logic [NUM_BTN-1:0] btn_rise_o
);

    logic [SYNC_STAGES-1:0][NUM_SW-1:0]  sw_q;
    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0]                  btn_prev_q;
    logic [NUM_BTN-1:0]                  btn_s;
    logic [SYNC_STAGES:0]                prime_q;
    logic [SYNC_STAGES:0]                prime_d;
    logic                                primed;

    assign sw_o  = sw_q[SYNC_STAGES-1];
    assign btn_s = btn_q[SYNC_STAGES-1];

    // Edges are suppressed until the chain and history hold real samples,
    // so a button held through reset is never reported as a press.
    assign prime_d = {prime_q[SYNC_STAGES-1:0], 1'b1};
    assign primed  = prime_q[SYNC_STAGES];

    assign btn_rise_o = primed ? (btn_s & ~btn_prev_q) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_q       <= '0;
            btn_q      <= '0;
            btn_prev_q <= '0;
            prime_q    <= '0;
        end else begin
            sw_q[0]  <= sw_i;
            btn_q[0] <= btn_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_q[i]  <= sw_q[i-1];
                btn_q[i] <= btn_q[i-1];
            end
            btn_prev_q <= btn_s;
            prime_q    <= prime_d;
        end
    end

endmodule

// File: rtl/port_controller.sv
// port_controller: CPU-visible I/O ports (displays, switches, button
// events, free-running timer) behind a two-state request FSM.
module port_controller
    import port_controller_pkg::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 cpu_en,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic                 port_ready,
    input  logic [NUM_SW-1:0]    sw,
    input  logic [NUM_BTN-1:0]   btn,
    input  logic                 show_sel,
    output logic [SHOW_W-1:0]    show_val,
    output logic                 bad_addr
);

    state_e               state_q, state_d;
    logic                 accept;

    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] val_q, val_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;

    logic [WORD_SIZE-1:0] disp0_q, disp0_d;
    logic [WORD_SIZE-1:0] disp1_q, disp1_d;
    logic [WORD_SIZE-1:0] timer_q, timer_d;
    logic [WORD_SIZE-1:0] portout_q, portout_d;
    logic [NUM_BTN-1:0]   btnev_q, btnev_d;
    logic                 ready_q, ready_d;
    logic                 bad_q, bad_d;
    logic [SHOW_W-1:0]    show_q, show_d;

    logic [NUM_SW-1:0]    sw_s;
    logic [NUM_BTN-1:0]   btn_rise;
    port_e                port_sel;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 do_rd;
    logic                 do_wr;
    logic                 wr_ok;

    input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk_i      (mclk),
        .rst_ni     (rst_n),
        .sw_i       (sw),
        .btn_i      (btn),
        .sw_o       (sw_s),
        .btn_rise_o (btn_rise)
    );

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_en && (portget || portset)) begin
                    accept  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A combined get+set is treated as a pure write.
    always_comb begin
        addr_d = addr_q;
        val_d  = val_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        if (accept) begin
            addr_d = portaddr;
            val_d  = portval;
            wr_d   = portset;
            rd_d   = portget & ~portset;
        end
    end

    always_comb begin
        port_sel = PORT_NONE;
        unique case (1'b1)
            addr_q == WORD_SIZE'(ADDR_DISP0): port_sel = PORT_DISP0;
            addr_q == WORD_SIZE'(ADDR_DISP1): port_sel = PORT_DISP1;
            addr_q == WORD_SIZE'(ADDR_SW):    port_sel = PORT_SW;
            addr_q == WORD_SIZE'(ADDR_BTNEV): port_sel = PORT_BTNEV;
            addr_q == WORD_SIZE'(ADDR_TIMER): port_sel = PORT_TIMER;
            default:                          port_sel = PORT_NONE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        unique case (port_sel)
            PORT_DISP0: rd_data = disp0_q;
            PORT_DISP1: rd_data = disp1_q;
            PORT_SW:    rd_data = WORD_SIZE'(sw_s);
            PORT_BTNEV: rd_data = WORD_SIZE'(btnev_q);
            PORT_TIMER: rd_data = timer_q;
            default:    rd_data = '0;
        endcase
    end

    assign do_rd = (state_q == ST_ACCESS) && rd_q;
    assign do_wr = (state_q == ST_ACCESS) && wr_q;
    assign wr_ok = do_wr && port_writable(port_sel);

    always_comb begin
        disp0_d   = disp0_q;
        disp1_d   = disp1_q;
        portout_d = portout_q;
        btnev_d   = btnev_q | btn_rise;
        ready_d   = (state_q == ST_ACCESS);
        bad_d     = bad_q | ((state_q == ST_ACCESS) && (port_sel == PORT_NONE));
        show_d    = show_sel ? SHOW_W'(disp1_q) : SHOW_W'(disp0_q);
        timer_d   = cpu_en ? timer_q + WORD_SIZE'(1) : timer_q;

        if (wr_ok && port_sel == PORT_DISP0) disp0_d = val_q;
        if (wr_ok && port_sel == PORT_DISP1) disp1_d = val_q;
        if (wr_ok && port_sel == PORT_TIMER) timer_d = val_q;

        if (do_rd) portout_d = rd_data;
        // Clear only what was visible to this read; a coincident edge survives.
        if (do_rd && port_sel == PORT_BTNEV) btnev_d = btn_rise;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            val_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            disp0_q   <= '0;
            disp1_q   <= '0;
            timer_q   <= '0;
            portout_q <= '0;
            btnev_q   <= '0;
            ready_q   <= 1'b0;
            bad_q     <= 1'b0;
            show_q    <= '0;
        end else begin
            addr_q    <= addr_d;
            val_q     <= val_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            disp0_q   <= disp0_d;
            disp1_q   <= disp1_d;
            timer_q   <= timer_d;
            portout_q <= portout_d;
            btnev_q   <= btnev_d;
            ready_q   <= ready_d;
            bad_q     <= bad_d;
            show_q    <= show_d;
        end
    end

    assign portout    = portout_q;
    assign port_ready = ready_q;
    assign bad_addr   = bad_q;
    assign show_val   = show_q;

endmodule

// File: tb/tb_port_controller.sv
// tb_port_controller: table-driven port accesses plus directed
// sequences for button events, timer, and reset during an access.
module tb_port_controller;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        cpu_en;
    logic [15:0] portaddr;
    logic [15:0] portval;
    logic        portget;
    logic        portset;
    logic [15:0] portout;
    logic        port_ready;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic        show_sel;
    logic [15:0] show_val;
    logic        bad_addr;

    int checks = 0;
    int errors = 0;

    port_controller #(
        .WORD_SIZE   (16),
        .SYNC_STAGES (2)
    ) dut (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .cpu_en     (cpu_en),
        .portaddr   (portaddr),
        .portval    (portval),
        .portget    (portget),
        .portset    (portset),
        .portout    (portout),
        .port_ready (port_ready),
        .sw         (sw),
        .btn        (btn),
        .show_sel   (show_sel),
        .show_val   (show_val),
        .bad_addr   (bad_addr)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic        g;
        logic        s;
        logic [15:0] addr;
        logic [15:0] val;
        logic [7:0]  sw;
        logic        sel;
        logic [15:0] exp_out;
        logic        exp_bad;
        logic [15:0] exp_show;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Issue one request; port_ready must appear at the second edge and last one cycle.
    task automatic access(input string nm, input logic g, input logic s,
                          input logic [15:0] a, input logic [15:0] v);
        int n;
        @(negedge mclk);
        cpu_en   = 1'b1;
        portget  = g;
        portset  = s;
        portaddr = a;
        portval  = v;
        n = 0;
        do begin
            @(negedge mclk);
            cpu_en  = 1'b0;
            portget = 1'b0;
            portset = 1'b0;
            n++;
        end while (!port_ready && n < 6);
        chk({nm, "_latency"}, n, 2);
        @(negedge mclk);
        chk({nm, "_ready_pulse"}, port_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        vt[0]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h1234};
        vt[1]  = '{1'b0, 1'b1, 16'h0001, 16'hBEEF, 8'h00, 1'b1, 16'h0000, 1'b0, 16'hBEEF};
        vt[2]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 16'h1234, 1'b0, 16'h1234};
        vt[3]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 8'h00, 1'b1, 16'hBEEF, 1'b0, 16'hBEEF};
        vt[4]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 8'hA5, 1'b0, 16'h00A5, 1'b0, 16'h1234};
        vt[5]  = '{1'b0, 1'b1, 16'h0002, 16'hFFFF, 8'h3C, 1'b0, 16'h00A5, 1'b0, 16'h1234};
        vt[6]  = '{1'b1, 1'b0, 16'h0002, 16'h0000, 8'h3C, 1'b1, 16'h003C, 1'b0, 16'hBEEF};
        vt[7]  = '{1'b1, 1'b1, 16'h0001, 16'h00AA, 8'h3C, 1'b1, 16'h003C, 1'b0, 16'h00AA};
        vt[8]  = '{1'b1, 1'b0, 16'h0001, 16'h0000, 8'h3C, 1'b0, 16'h00AA, 1'b0, 16'h1234};
        vt[9]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 8'h3C, 1'b0, 16'h0000, 1'b0, 16'h1234};
        vt[10] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 8'h3C, 1'b1, 16'h0000, 1'b1, 16'h00AA};
        vt[11] = '{1'b0, 1'b1, 16'h0000, 16'h5555, 8'h3C, 1'b0, 16'h0000, 1'b1, 16'h5555};
        vt[12] = '{1'b0, 1'b1, 16'h8000, 16'h1111, 8'h3C, 1'b0, 16'h0000, 1'b1, 16'h5555};
        vt[13] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'h3C, 1'b0, 16'h5555, 1'b1, 16'h5555};

        rst_n    = 1'b0;
        cpu_en   = 1'b0;
        portaddr = '0;
        portval  = '0;
        portget  = 1'b0;
        portset  = 1'b0;
        sw       = '0;
        btn      = '0;
        show_sel = 1'b0;

        repeat (3) @(negedge mclk);
        chk("rst_portout", portout, 0);
        chk("rst_ready", port_ready, 0);
        chk("rst_show", show_val, 0);
        chk("rst_bad", bad_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge mclk);

        for (int i = 0; i < NV; i++) begin
            sw       = vt[i].sw;
            show_sel = vt[i].sel;
            repeat (4) @(negedge mclk);
            access($sformatf("v%0d", i), vt[i].g, vt[i].s, vt[i].addr, vt[i].val);
            chk($sformatf("v%0d_portout", i), portout, vt[i].exp_out);
            chk($sformatf("v%0d_bad", i), bad_addr, vt[i].exp_bad);
            chk($sformatf("v%0d_show", i), show_val, vt[i].exp_show);
        end

        // Button press then read-clear.
        btn = 4'b0100;
        repeat (5) @(negedge mclk);
        btn = 4'b0000;
        repeat (3) @(negedge mclk);
        access("btn_rd1", 1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("btn_first", portout, 16'h0004);
        access("btn_rd2", 1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("btn_cleared", portout, 16'h0000);

        // Edge of btn[1] lands on the same edge as the clearing read.
        btn = 4'b0001;
        repeat (5) @(negedge mclk);
        @(negedge mclk);
        btn = 4'b0011;
        access("btn_rd3", 1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("btn_coincident_read", portout, 16'h0001);
        access("btn_rd4", 1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("btn_coincident_kept", portout, 16'h0002);

        // Timer load wins over increment; a request during ACCESS is ignored.
        @(negedge mclk);
        cpu_en   = 1'b1;
        portset  = 1'b1;
        portaddr = 16'h0004;
        portval  = 16'h0100;
        @(negedge mclk);
        portset  = 1'b0;
        portget  = 1'b1;
        portaddr = 16'h0000;
        @(negedge mclk);
        cpu_en  = 1'b0;
        portget = 1'b0;
        chk("prio_ready", port_ready, 1);
        @(negedge mclk);
        chk("busy_req_ignored", port_ready, 0);
        access("tmr_rd1", 1'b1, 1'b0, 16'h0004, 16'h0000);
        chk("timer_load_priority", portout, 16'h0101);

        // Wrap: FFFF, one tick, then the read's own tick.
        access("tmr_wr", 1'b0, 1'b1, 16'h0004, 16'hFFFF);
        @(negedge mclk);
        cpu_en = 1'b1;
        @(negedge mclk);
        cpu_en = 1'b0;
        access("tmr_rd2", 1'b1, 1'b0, 16'h0004, 16'h0000);
        chk("timer_wrap", portout, 16'h0001);
        chk("bad_sticky", bad_addr, 1);

        // Reset while a DISP0 write is in ACCESS; btn[3] held through reset.
        @(negedge mclk);
        show_sel = 1'b0;
        btn      = 4'b1010;
        cpu_en   = 1'b1;
        portset  = 1'b1;
        portaddr = 16'h0000;
        portval  = 16'h9999;
        @(negedge mclk);
        cpu_en  = 1'b0;
        portset = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("arst_show", show_val, 0);
        chk("arst_bad", bad_addr, 0);
        chk("arst_portout", portout, 0);
        @(negedge mclk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge mclk);
            if (port_ready) seen = 1'b1;
        end
        chk("arst_no_ready", seen, 0);
        chk("arst_disp0_show", show_val, 16'h0000);
        access("arst_rd0", 1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("arst_disp0", portout, 16'h0000);
        access("held_rd", 1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("held_btn_no_event", portout, 16'h0000);
        btn = 4'b0010;
        repeat (5) @(negedge mclk);
        btn = 4'b1010;
        repeat (5) @(negedge mclk);
        access("repress_rd", 1'b1, 1'b0, 16'h0003, 16'h0000);
        chk("repress_event", portout, 16'h0008);
        chk("bad_after_reset", bad_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
